// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one bit per cycle, a shift-add multiplier and a restoring divider.
// Both share a single {hiWork, loWork} working register. A sign/result fix-up cycle runs before DONE.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   SrcA,
  input  logic [WIDTH-1:0]   SrcB,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] MultAns,
  output logic               DivZero
);

  // FINISH is the non-busy cycle between the last iteration and DONE.
  // It applies sign correction and the divide-by-zero override.
  typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;

  state_t             stateReg, stateNext;
  logic [1:0]         opReg;
  logic [WIDTH-1:0]   aReg, bReg;
  logic [WIDTH-1:0]   hiWork, loWork;
  logic [5:0]         countReg;
  logic [2*WIDTH-1:0] multAnsReg;
  logic               divZeroReg;

  logic               accept;
  logic               isDiv, aNeg, bNeg;
  logic [WIDTH-1:0]   magA, magB;
  logic               inANeg, inBNeg;
  logic [WIDTH-1:0]   inMagA, inMagB;

  // Latched operand magnitudes feed the iteration.
  assign isDiv = opReg[1];
  assign aNeg  = opReg[0] & aReg[WIDTH-1];
  assign bNeg  = opReg[0] & bReg[WIDTH-1];
  assign magA  = aNeg ? -aReg : aReg;
  assign magB  = bNeg ? -bReg : bReg;

  // The magnitudes of the incoming operands seed the working register on acceptance.
  assign inANeg = op[0] & SrcA[WIDTH-1];
  assign inBNeg = op[0] & SrcB[WIDTH-1];
  assign inMagA = inANeg ? -SrcA : SrcA;
  assign inMagB = inBNeg ? -SrcB : SrcB;

  assign accept = start && ((stateReg == IDLE) || (stateReg == DONE));

  // Multiply step: the multiplier sits in loWork and is consumed from the LSB.
  // The partial sum grows in hiWork.
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sumWide;
  logic [WIDTH-1:0] mulHi, mulLo;

  assign addend  = loWork[0] ? magA : '0;
  assign sumWide = {1'b0, hiWork} + {1'b0, addend};
  assign mulHi   = sumWide[WIDTH:1];
  assign mulLo   = {sumWide[0], loWork[WIDTH-1:1]};

  // Restoring divide step: the dividend shifts out of loWork into the partial remainder.
  // Quotient bits shift into loWork from the LSB.
  logic [WIDTH:0]   shifted;
  logic             geDivisor;
  logic [WIDTH-1:0] diffLow;
  logic [WIDTH-1:0] divHi, divLo;

  assign shifted   = {hiWork, loWork[WIDTH-1]};
  assign geDivisor = shifted >= {1'b0, magB};
  assign diffLow   = shifted[WIDTH-1:0] - magB;
  assign divHi     = geDivisor ? diffLow : shifted[WIDTH-1:0];
  assign divLo     = {loWork[WIDTH-2:0], geDivisor};

  // Final result formation, sampled in FINISH.
  logic [2*WIDTH-1:0] productMag, productSigned;
  logic [WIDTH-1:0]   quotSigned, remSigned;
  logic               divByZero;
  logic [2*WIDTH-1:0] resultValue;

  assign productMag    = {hiWork, loWork};
  assign productSigned = (aNeg ^ bNeg) ? -productMag : productMag;
  assign quotSigned    = (aNeg ^ bNeg) ? -loWork : loWork;
  assign remSigned     = aNeg ? -hiWork : hiWork;
  assign divByZero     = isDiv && (bReg == '0);

  always_comb begin
    resultValue = productSigned;
    if (isDiv) begin
      if (divByZero) begin
        resultValue = {{WIDTH{1'b1}}, aReg};
      end else begin
        resultValue = {quotSigned, remSigned};
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    busy      = 1'b0;
    done      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start) stateNext = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (countReg == 6'(WIDTH - 1)) stateNext = FINISH;
      end
      FINISH: begin
        stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = start ? RUN : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= IDLE;
      opReg      <= '0;
      aReg       <= '0;
      bReg       <= '0;
      hiWork     <= '0;
      loWork     <= '0;
      countReg   <= '0;
      multAnsReg <= '0;
      divZeroReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (accept) begin
        opReg      <= op;
        aReg       <= SrcA;
        bReg       <= SrcB;
        hiWork     <= '0;
        loWork     <= op[1] ? inMagA : inMagB;
        countReg   <= '0;
        divZeroReg <= 1'b0;
      end else if (stateReg == RUN) begin
        countReg <= countReg + 6'd1;
        if (isDiv) begin
          hiWork <= divHi;
          loWork <= divLo;
        end else begin
          hiWork <= mulHi;
          loWork <= mulLo;
        end
      end else if (stateReg == FINISH) begin
        multAnsReg <= resultValue;
        divZeroReg <= divByZero;
      end
    end
  end

  assign MultAns = multAnsReg;
  assign DivZero = divZeroReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a vector table plus hand-written sequences.
// The sequences cover mid-run start, back-to-back operation, reset abort and reset/start priority.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] SrcA, SrcB;
  logic        busy, done, DivZero;
  logic [63:0] MultAns;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .SrcA(SrcA), .SrcB(SrcB),
    .busy(busy), .done(done), .MultAns(MultAns), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] ans;
    logic        dz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%h", name, act);
    end
  endtask

  // Present an operation; it is accepted at the following posedge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    SrcA  = a;
    SrcB  = b;
    @(posedge clk);
  endtask

  // Follow an accepted operation to its done pulse.
  // injectAt > 0 re-asserts start with junk operands in that RUN cycle.
  task automatic waitDone(input string name, input logic [63:0] expAns, input logic expDz,
                          input int injectAt);
    int busyCnt = 0;
    int lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) begin
        lat = i - 1;
        break;
      end
      start = 1'b0;
      if (injectAt != 0 && i == injectAt) begin
        start = 1'b1;
        op    = 2'b11;
        SrcA  = 32'h1234_5678;
        SrcB  = 32'h0000_0003;
      end
    end
    start = 1'b0;
    if (lat < 0) begin
      tests++;
      fails++;
      $display("FAIL %s-timeout: got no done, expected done within 60 cycles", name);
    end else begin
      check({name, "-latency"}, 64'(lat), 64'd33);
      check({name, "-busyCycles"}, 64'(busyCnt), 64'd32);
      check({name, "-MultAns"}, MultAns, expAns);
      check({name, "-DivZero"}, 64'(DivZero), 64'(expDz));
    end
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
    vecs[2]  = '{2'b00, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, 1'b0};
    vecs[3]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0};
    vecs[4]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0};
    vecs[5]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFD_FFFF_FFFF, 1'b0};
    vecs[6]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0};
    vecs[7]  = '{2'b10, 32'd100,       32'd0,         64'hFFFF_FFFF_0000_0064, 1'b1};
    vecs[8]  = '{2'b10, 32'd100,       32'd7,         64'h0000_000E_0000_0002, 1'b0};
    vecs[9]  = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 64'hFFFF_FFFD_0000_0001, 1'b0};
    vecs[10] = '{2'b11, 32'hFFFF_FF9C, 32'd0,         64'hFFFF_FFFF_FFFF_FF9C, 1'b1};
    vecs[11] = '{2'b10, 32'hFFFF_FFFF, 32'd1,         64'hFFFF_FFFF_0000_0000, 1'b0};
    vecs[12] = '{2'b10, 32'd5,         32'd10,        64'h0000_0000_0000_0005, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    SrcA  = '0;
    SrcB  = '0;
    repeat (2) @(negedge clk);
    check("reset-busy", 64'(busy), 64'd0);
    check("reset-done", 64'(done), 64'd0);
    check("reset-MultAns", MultAns, 64'd0);
    check("reset-DivZero", 64'(DivZero), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 13; k++) begin
      launch(vecs[k].op, vecs[k].a, vecs[k].b);
      waitDone($sformatf("vec%0d", k), vecs[k].ans, vecs[k].dz, 0);
      @(negedge clk);
      check($sformatf("vec%0d-donePulse", k), 64'(done), 64'd0);
      check($sformatf("vec%0d-heldAns", k), MultAns, vecs[k].ans);
      check($sformatf("vec%0d-stickyDz", k), 64'(DivZero), 64'(vecs[k].dz));
    end

    // A start during RUN is ignored. A start in the DONE cycle chains the next op.
    launch(2'b00, 32'd6, 32'd7);
    waitDone("ignoreStart", 64'd42, 1'b0, 5);
    launch(2'b11, 32'hFFFF_FFF9, 32'd2);
    waitDone("backToBack", 64'hFFFF_FFFD_FFFF_FFFF, 1'b0, 0);
    @(negedge clk);
    check("backToBack-donePulse", 64'(done), 64'd0);

    // Reset in RUN cycle 10 aborts the operation and suppresses its done pulse.
    launch(2'b00, 32'd3, 32'd5);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort-busyBefore", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort-busy", 64'(busy), 64'd0);
    check("abort-done", 64'(done), 64'd0);
    check("abort-MultAns", MultAns, 64'd0);
    check("abort-DivZero", 64'(DivZero), 64'd0);
    begin
      int doneCnt = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) doneCnt++;
      end
      check("abort-noDone", 64'(doneCnt), 64'd0);
    end

    // Reset wins over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    op    = 2'b00;
    SrcA  = 32'd9;
    SrcB  = 32'd9;
    @(negedge clk);
    check("resetPriority-busy", 64'(busy), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("resetPriority-idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
